// File: rtl/ngs_boot_core_mul_pipe_if.sv
// Operand/result bundle between the E-stage operand muxes and the pipelined multiplier.
// Latency: none, wiring only.
// Backpressure: none; en is the CPU pipeline advance and freezes the multiplier when low.
interface ngs_boot_core_mul_pipe_if #(
    parameter int DATA_W = 32
);
    logic              en;
    logic              in_valid;
    logic [1:0]        op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              out_valid;
    logic [DATA_W-1:0] out_lo;
    logic [DATA_W-1:0] out_hi;
    logic              busy;

    // CPU side: drives operands and the advance enable, receives the product.
    modport master (
        output en, in_valid, op, src1, src2,
        input  out_valid, out_lo, out_hi, busy
    );

    // Multiplier side.
    modport slave (
        input  en, in_valid, op, src1, src2,
        output out_valid, out_lo, out_hi, busy
    );
endinterface

// File: rtl/ngs_boot_core_mul_pipe.sv
// Pipelined signed/unsigned integer multiplier assembled from PART_W x PART_W slice products.
// Latency: result one enabled edge after the accepting edge (two with OUT_REG=1); one op per enabled edge.
// Backpressure: none internal; en=0 freezes every stage so CPU stalls hold results in place.
// Build option: define NGS_BOOT_CORE_MUL_HI_EN for the full double-width product on out_hi.
module ngs_boot_core_mul_pipe #(
    parameter int DATA_W  = 32,
    parameter int PART_W  = 16,
    parameter int OUT_REG = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    ngs_boot_core_mul_pipe_if.slave bus
);

    localparam int PART_DIV = (PART_W > 0) ? PART_W : 1;
    localparam int NPART    = DATA_W / PART_DIV;
    localparam int NPAIR    = NPART * NPART;
`ifdef NGS_BOOT_CORE_MUL_HI_EN
    localparam bit HI_EN    = 1'b1;
    localparam int SUM_W    = 2 * DATA_W;
`else
    localparam bit HI_EN    = 1'b0;
    localparam int SUM_W    = DATA_W;
`endif

    // Slices must tile the operand exactly and be wide enough to be a real multiplier cell.
    if ((PART_W < 2) || ((DATA_W % PART_DIV) != 0)) begin : g_param_check
        $error("ngs_boot_core_mul_pipe: DATA_W must be a multiple of PART_W and PART_W >= 2");
    end

    // ------------------------------------------------------------------
    // Stage P: slice products
    // ------------------------------------------------------------------
    logic p_vld;

    // Valid bit follows in_valid on every enabled edge so bubbles travel with the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_vld <= 1'b0;
        end else if (bus.en) begin
            p_vld <= bus.in_valid;
        end
    end

    // Each slice product pre-aligned to its weight; skipped cells contribute zero.
    logic [SUM_W-1:0] term [NPAIR];

    for (genvar i = 0; i < NPART; i++) begin : g_row
        for (genvar j = 0; j < NPART; j++) begin : g_col
            // Without the high word, cells whose weight lands at or above DATA_W are never built.
            if (HI_EN || ((i + j) < NPART)) begin : g_cell
                logic [2*PART_W-1:0] a_ext;
                logic [2*PART_W-1:0] b_ext;
                logic [2*PART_W-1:0] pp_q;

                assign a_ext = {{PART_W{1'b0}}, bus.src1[i*PART_W +: PART_W]};
                assign b_ext = {{PART_W{1'b0}}, bus.src2[j*PART_W +: PART_W]};

                // Unsigned slice product captured on every enabled edge.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        pp_q <= '0;
                    end else if (bus.en) begin
                        pp_q <= a_ext * b_ext;
                    end
                end

                assign term[i*NPART + j] = SUM_W'(pp_q) << ((i + j) * PART_W);
            end else begin : g_skip
                assign term[i*NPART + j] = '0;
            end
        end
    end

`ifdef NGS_BOOT_CORE_MUL_HI_EN
    logic [1:0]        op_q;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic              s1_neg;
    logic              s2_neg;

    // Op and raw operands ride alongside the slice products; the operand MSBs are the sign bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= 2'b00;
            src1_q <= '0;
            src2_q <= '0;
        end else if (bus.en) begin
            op_q   <= bus.op;
            src1_q <= bus.src1;
            src2_q <= bus.src2;
        end
    end

    // src1 is signed for MULXSU/MULXSS, src2 only for MULXSS.
    assign s1_neg = op_q[1] & src1_q[DATA_W-1];
    assign s2_neg = (op_q == 2'b11) & src2_q[DATA_W-1];
`else
    // The op only changes upper-word bits, so the low-word-only build ignores it.
    logic unused_op;
    assign unused_op = ^bus.op;
`endif

    // ------------------------------------------------------------------
    // Stage S: alignment sum and sign correction
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] sum_d;

    // Add the aligned slice products, then apply the two's-complement weight of negative operands.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NPAIR; k++) begin
            sum_d = sum_d + term[k];
        end
`ifdef NGS_BOOT_CORE_MUL_HI_EN
        // A negative signed operand's MSB weighs -2^(DATA_W-1), so the unsigned
        // product over-counts by (other operand) << DATA_W.
        if (s1_neg) begin
            sum_d = sum_d - {src2_q, {DATA_W{1'b0}}};
        end
        if (s2_neg) begin
            sum_d = sum_d - {src1_q, {DATA_W{1'b0}}};
        end
`endif
    end

    logic             s_vld;
    logic [SUM_W-1:0] s_sum;

    // Stage S register holds the assembled product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_vld <= 1'b0;
            s_sum <= '0;
        end else if (bus.en) begin
            s_vld <= p_vld;
            s_sum <= sum_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional output stage
    // ------------------------------------------------------------------
    logic             f_vld;
    logic [SUM_W-1:0] f_sum;
    logic             o_busy;

    if (OUT_REG != 0) begin : g_oreg
        logic             o_vld;
        logic [SUM_W-1:0] o_sum;

        // Extra retiming register toward the writeback stage.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                o_vld <= 1'b0;
                o_sum <= '0;
            end else if (bus.en) begin
                o_vld <= s_vld;
                o_sum <= s_sum;
            end
        end

        assign f_vld  = o_vld;
        assign f_sum  = o_sum;
        assign o_busy = o_vld;
    end else begin : g_onreg
        assign f_vld  = s_vld;
        assign f_sum  = s_sum;
        assign o_busy = 1'b0;
    end

    assign bus.out_valid = f_vld;
    assign bus.out_lo    = f_sum[DATA_W-1:0];
`ifdef NGS_BOOT_CORE_MUL_HI_EN
    assign bus.out_hi    = f_sum[SUM_W-1:DATA_W];
`else
    assign bus.out_hi    = '0;
`endif
    // Any occupied stage means an op is still in flight.
    assign bus.busy      = p_vld | s_vld | o_busy;

endmodule

// File: tb/tb_ngs_boot_core_mul_pipe.sv
// Scoreboard bench for the pipelined multiplier: a 32/16 instance and a 24/8 OUT_REG=1 instance.
// Expected products are hand-computed; out_hi expectations collapse to 0 without NGS_BOOT_CORE_MUL_HI_EN.
// A monitor per instance pops the queue on each fresh result and checks held outputs during stalls.
module tb_ngs_boot_core_mul_pipe;

`ifdef NGS_BOOT_CORE_MUL_HI_EN
    localparam bit HI = 1'b1;
`else
    localparam bit HI = 1'b0;
`endif

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    ngs_boot_core_mul_pipe_if #(.DATA_W(32)) m32 ();
    ngs_boot_core_mul_pipe_if #(.DATA_W(24)) m24 ();

    ngs_boot_core_mul_pipe #(.DATA_W(32), .PART_W(16), .OUT_REG(0)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (m32)
    );

    ngs_boot_core_mul_pipe #(.DATA_W(24), .PART_W(8), .OUT_REG(1)) u_dut24 (
        .clk   (clk),
        .reset (reset),
        .bus   (m24)
    );

    always #5 clk = ~clk;

    exp_t q32[$];
    exp_t q24[$];
    exp_t hold32;
    exp_t hold24;
    bit   hold32_vld = 1'b0;
    bit   hold24_vld = 1'b0;
    int   edges32 = 0;
    int   edges24 = 0;
    bit   en32_last = 1'b0;
    bit   en24_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // Count enabled edges so each result can be checked for exact latency.
    always @(posedge clk) begin
        en32_last <= m32.en && !reset;
        en24_last <= m24.en && !reset;
        if (m32.en && !reset) edges32 <= edges32 + 1;
        if (m24.en && !reset) edges24 <= edges24 + 1;
    end

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin
        if (reset) begin
            hold32_vld = 1'b0;
        end else if (en32_last) begin
            if (m32.out_valid) begin
                if (q32.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d32_unexpected: out_valid=1 with nothing pending, lo=0x%08h", m32.out_lo);
                end else begin
                    hold32 = q32.pop_front();
                    hold32_vld = 1'b1;
                    chk("d32_lo", m32.out_lo, hold32.lo);
                    chk("d32_hi", m32.out_hi, hold32.hi);
                    chk("d32_latency", edges32, hold32.due);
                end
            end else begin
                hold32_vld = 1'b0;
            end
        end else begin
            chk("d32_stall_vld", {31'd0, m32.out_valid}, {31'd0, hold32_vld});
            if (hold32_vld) begin
                chk("d32_stall_lo", m32.out_lo, hold32.lo);
                chk("d32_stall_hi", m32.out_hi, hold32.hi);
            end
        end
    end

    // Monitor for the 24-bit instance.
    always @(negedge clk) begin
        if (reset) begin
            hold24_vld = 1'b0;
        end else if (en24_last) begin
            if (m24.out_valid) begin
                if (q24.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d24_unexpected: out_valid=1 with nothing pending, lo=0x%06h", m24.out_lo);
                end else begin
                    hold24 = q24.pop_front();
                    hold24_vld = 1'b1;
                    chk("d24_lo", {8'h00, m24.out_lo}, hold24.lo);
                    chk("d24_hi", {8'h00, m24.out_hi}, hold24.hi);
                    chk("d24_latency", edges24, hold24.due);
                end
            end else begin
                hold24_vld = 1'b0;
            end
        end else begin
            chk("d24_stall_vld", {31'd0, m24.out_valid}, {31'd0, hold24_vld});
        end
    end

    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lo, input logic [31:0] hi);
        exp_t e;
        e.lo  = lo;
        e.hi  = HI ? hi : 32'd0;
        e.due = edges32 + 2;
        q32.push_back(e);
        m32.en = 1'b1; m32.in_valid = 1'b1; m32.op = op; m32.src1 = a; m32.src2 = b;
        @(posedge clk); #1;
    endtask

    task automatic issue24(input logic [1:0] op, input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] lo, input logic [23:0] hi);
        exp_t e;
        e.lo  = {8'h00, lo};
        e.hi  = HI ? {8'h00, hi} : 32'd0;
        e.due = edges24 + 3;
        q24.push_back(e);
        m24.en = 1'b1; m24.in_valid = 1'b1; m24.op = op; m24.src1 = a; m24.src2 = b;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        m32.en = 1'b1; m32.in_valid = 1'b0;
        m24.en = 1'b1; m24.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        m32.en = 1'b0; m32.in_valid = 1'b0; m32.op = 2'b00; m32.src1 = '0; m32.src2 = '0;
        m24.en = 1'b0; m24.in_valid = 1'b0; m24.op = 2'b00; m24.src1 = '0; m24.src2 = '0;
        #1;
        chk("rst_d32_valid", {31'd0, m32.out_valid}, 32'd0);
        chk("rst_d32_busy",  {31'd0, m32.busy},      32'd0);
        chk("rst_d32_lo",    m32.out_lo,             32'd0);
        chk("rst_d32_hi",    m32.out_hi,             32'd0);
        chk("rst_d24_valid", {31'd0, m24.out_valid}, 32'd0);
        chk("rst_d24_busy",  {31'd0, m24.busy},      32'd0);

        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        idle(2);

        // Directed signed/unsigned/mixed vectors, issued back to back.
        issue32(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
        issue32(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000);
        issue32(2'b11, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000);
        issue32(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF);
        issue32(2'b00, 32'h00012345, 32'h00010000, 32'h23450000, 32'h00000001);
        issue32(2'b10, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFA, 32'h00000002);
        issue32(2'b11, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFA, 32'hFFFFFFFF);
        idle(1);
        issue32(2'b01, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001);
        idle(3);

        // Back-to-back stream with a 5-cycle stall mid-stream; the stalled in_valid must be ignored.
        issue32(2'b00, 32'h00000002, 32'h00000003, 32'h00000006, 32'h00000000);
        issue32(2'b11, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFB, 32'hFFFFFFFF);
        m32.en = 1'b0; m32.in_valid = 1'b1; m32.op = 2'b01; m32.src1 = 32'h0000DEAD; m32.src2 = 32'h00000011;
        repeat (5) begin
            @(posedge clk); #1;
        end
        issue32(2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001);
        issue32(2'b10, 32'h80000000, 32'h00000002, 32'h00000000, 32'hFFFFFFFF);
        idle(4);

        // 24-bit slices of 8 with the output register.
        issue24(2'b11, 24'h800000, 24'h000002, 24'h000000, 24'hFFFFFF);
        issue24(2'b01, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 24'hFFFFFE);
        issue24(2'b00, 24'h000123, 24'h000100, 24'h012300, 24'h000000);
        issue24(2'b10, 24'hFFFFFF, 24'h000003, 24'hFFFFFD, 24'hFFFFFF);
        issue24(2'b11, 24'hFFFFFF, 24'hFFFFFF, 24'h000001, 24'h000000);
        idle(5);

        chk("q32_drained", q32.size(), 32'd0);
        chk("q24_drained", q24.size(), 32'd0);
        chk("idle_d32_busy", {31'd0, m32.busy}, 32'd0);
        chk("idle_d24_busy", {31'd0, m24.busy}, 32'd0);

        // Asynchronous reset with two ops in flight: everything drops at once, nothing resurfaces.
        issue32(2'b00, 32'h00000007, 32'h00000007, 32'h00000031, 32'h00000000);
        issue32(2'b00, 32'h00000009, 32'h00000009, 32'h00000051, 32'h00000000);
        chk("inflight_busy", {31'd0, m32.busy}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, m32.out_valid}, 32'd0);
        chk("async_rst_busy",  {31'd0, m32.busy},      32'd0);
        q32.delete();
        m32.in_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        idle(6);
        chk("post_rst_busy", {31'd0, m32.busy}, 32'd0);
        chk("post_rst_valid", {31'd0, m32.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
